// File: rtl/rtc_ad_bus_cycle.sv
// Multiplexed address/data bus-cycle generator for the external RTC chip.
// One accepted request produces address phase, turnaround, data phase and a done pulse.
module rtc_ad_bus_cycle #(
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 3
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       req,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] ADin,
  output logic [7:0] ADout,
  output logic       bus_oe,
  output logic       ad,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done
);

  localparam int MAX_PH = (T_PULSE > T_HOLD) ? ((T_PULSE > T_GAP) ? T_PULSE : T_GAP)
                                             : ((T_HOLD > T_GAP) ? T_HOLD : T_GAP);
  localparam int CW = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

  localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_GAP   = CW'(T_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_A_ASSERT, S_A_HOLD, S_GAP, S_D_ASSERT, S_D_HOLD, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rw_q, rw_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [7:0]    adout_q, adout_d;
  logic          oe_q, oe_d;
  logic          ad_q, ad_d;
  logic          cs_q, cs_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (req) begin
          state_d = S_A_ASSERT;
          cnt_d   = LD_PULSE;
          rw_d    = rw;
          addr_d  = addr;
          wdata_d = wdata;
        end
      end
      S_A_ASSERT, S_A_HOLD, S_GAP, S_D_ASSERT, S_D_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          unique case (state_q)
            S_A_ASSERT: begin state_d = S_A_HOLD;   cnt_d = LD_HOLD;  end
            S_A_HOLD:   begin state_d = S_GAP;      cnt_d = LD_GAP;   end
            S_GAP:      begin state_d = S_D_ASSERT; cnt_d = LD_PULSE; end
            S_D_ASSERT: begin
              state_d = S_D_HOLD;
              cnt_d   = LD_HOLD;
              if (rw_q) rdata_d = ADin;
            end
            default:    begin state_d = S_DONE;     cnt_d = '0;       end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    adout_d = 8'h00;
    oe_d    = 1'b0;
    ad_d    = 1'b1;
    cs_d    = 1'b1;
    rd_d    = 1'b1;
    wr_d    = 1'b1;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    unique case (state_d)
      S_IDLE: busy_d = 1'b0;
      S_DONE: begin busy_d = 1'b0; done_d = 1'b1; end
      S_A_ASSERT: begin
        ad_d = 1'b0; cs_d = 1'b0; wr_d = 1'b0; oe_d = 1'b1; adout_d = addr_d;
      end
      S_A_HOLD: begin
        ad_d = 1'b0; oe_d = 1'b1; adout_d = addr_d;
      end
      S_GAP: ;
      S_D_ASSERT: begin
        cs_d = 1'b0;
        if (rw_d) rd_d = 1'b0;
        else begin wr_d = 1'b0; oe_d = 1'b1; adout_d = wdata_d; end
      end
      S_D_HOLD: if (!rw_d) begin oe_d = 1'b1; adout_d = wdata_d; end
      default: busy_d = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      adout_q <= 8'h00;
      oe_q    <= 1'b0;
      ad_q    <= 1'b1;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      adout_q <= adout_d;
      oe_q    <= oe_d;
      ad_q    <= ad_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ADout  = adout_q;
  assign bus_oe = oe_q;
  assign ad     = ad_q;
  assign cs     = cs_q;
  assign rd     = rd_q;
  assign wr     = wr_q;
  assign rdata  = rdata_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_rtc_ad_bus_cycle.sv
// Bench for rtc_ad_bus_cycle: default-timing instance plus a 1/1/1 instance,
// each cycle compared against a phase-arithmetic reference model.
module tb_rtc_ad_bus_cycle;

  localparam int TP = 4, TH = 2, TG = 3;

  typedef struct packed {
    logic       ad, cs, rd, wr, oe, busy, done;
    logic [7:0] adout;
  } obs_t;

  logic       CLK = 1'b0;
  logic       reset, req0, req1, rw;
  logic [7:0] addr, wdata, ADin;

  logic [7:0] adout0, rdata0, adout1, rdata1;
  logic       oe0, ad0, cs0, rd0, wr0, busy0, done0;
  logic       oe1, ad1, cs1, rd1, wr1, busy1, done1;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_rdata [2];

  always #5 CLK = ~CLK;

  rtc_ad_bus_cycle #(.T_PULSE(TP), .T_HOLD(TH), .T_GAP(TG)) dut0 (
    .CLK(CLK), .reset(reset), .req(req0), .rw(rw), .addr(addr), .wdata(wdata),
    .ADin(ADin), .ADout(adout0), .bus_oe(oe0), .ad(ad0), .cs(cs0), .rd(rd0),
    .wr(wr0), .rdata(rdata0), .busy(busy0), .done(done0)
  );

  rtc_ad_bus_cycle #(.T_PULSE(1), .T_HOLD(1), .T_GAP(1)) dut1 (
    .CLK(CLK), .reset(reset), .req(req1), .rw(rw), .addr(addr), .wdata(wdata),
    .ADin(ADin), .ADout(adout1), .bus_oe(oe1), .ad(ad1), .cs(cs1), .rd(rd1),
    .wr(wr1), .rdata(rdata1), .busy(busy1), .done(done1)
  );

  // Expected pins in cycle j after the accepting edge (j<1 or past DONE = idle).
  function automatic obs_t model(int j, int np, int nh, int ng, bit r,
                                 logic [7:0] a, logic [7:0] w);
    obs_t e;
    int b1, b2, b3, b4, b5;
    e  = '{ad:1'b1, cs:1'b1, rd:1'b1, wr:1'b1, oe:1'b0, busy:1'b0, done:1'b0, adout:8'h00};
    b1 = np; b2 = b1 + nh; b3 = b2 + ng; b4 = b3 + np; b5 = b4 + nh;
    if (j >= 1 && j <= b5) e.busy = 1'b1;
    if (j < 1) ;
    else if (j <= b1) begin e.ad = 0; e.cs = 0; e.wr = 0; e.oe = 1; e.adout = a; end
    else if (j <= b2) begin e.ad = 0; e.oe = 1; e.adout = a; end
    else if (j <= b3) ;
    else if (j <= b4) begin
      e.cs = 0;
      if (r) e.rd = 0;
      else begin e.wr = 0; e.oe = 1; e.adout = w; end
    end
    else if (j <= b5) begin if (!r) begin e.oe = 1; e.adout = w; end end
    else if (j == b5 + 1) e.done = 1'b1;
    return e;
  endfunction

  function automatic obs_t observe(int sel);
    if (sel == 0) return '{ad:ad0, cs:cs0, rd:rd0, wr:wr0, oe:oe0, busy:busy0, done:done0, adout:adout0};
    return '{ad:ad1, cs:cs1, rd:rd1, wr:wr1, oe:oe1, busy:busy1, done:done1, adout:adout1};
  endfunction

  function automatic logic [7:0] rdata_of(int sel);
    return (sel == 0) ? rdata0 : rdata1;
  endfunction

  // Starts at a negedge; issues one request and checks every cycle through DONE.
  // Returns at the negedge inside the DONE cycle so a follow-on request lands there.
  task automatic do_transfer(input string name, input int sel, input bit r,
                             input logic [7:0] a, input logic [7:0] w,
                             input logic [7:0] rv, input bit spur);
    int np, nh, ng, n, d_lo, d_hi;
    obs_t e, o;
    np = (sel == 0) ? TP : 1;
    nh = (sel == 0) ? TH : 1;
    ng = (sel == 0) ? TG : 1;
    n    = 2 * np + 2 * nh + ng;
    d_lo = np + nh + ng + 1;
    d_hi = np + nh + ng + np;
    rw = r; addr = a; wdata = w;
    if (sel == 0) req0 = 1'b1; else req1 = 1'b1;
    for (int j = 1; j <= n + 1; j++) begin
      @(negedge CLK);
      req0 = 1'b0; req1 = 1'b0;
      rw = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
      e = model(j, np, nh, ng, r, a, w);
      o = observe(sel);
      if (!e.oe) begin e.adout = 8'h00; o.adout = 8'h00; end
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s pins j=%0d got=%h exp=%h", name, j, o, e);
      end
      if (r && j > d_hi) exp_rdata[sel] = rv;
      checks++;
      if (rdata_of(sel) !== exp_rdata[sel]) begin
        errors++;
        $display("FAIL %s rdata j=%0d got=%h exp=%h", name, j, rdata_of(sel), exp_rdata[sel]);
      end
      ADin = (r && j >= d_lo && j <= d_hi) ? rv : 8'hFF;
      if (spur && (j == 3 || j == 10)) begin
        if (sel == 0) req0 = 1'b1; else req1 = 1'b1;
      end
    end
  endtask

  task automatic idle_cycles(input string name, input int sel, input int cnt);
    obs_t e, o;
    e = model(0, 1, 1, 1, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < cnt; i++) begin
      @(negedge CLK);
      o = observe(sel);
      o.adout = 8'h00;
      checks++;
      if (o !== e || rdata_of(sel) !== exp_rdata[sel]) begin
        errors++;
        $display("FAIL %s idle i=%0d got=%h/%h exp=%h/%h", name, i, o, rdata_of(sel), e, exp_rdata[sel]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    reset = 1'b0; req0 = 1'b1; req1 = 1'b1; rw = 1'b1; addr = 8'h5A;
    exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      for (int s = 0; s < 2; s++) begin
        checks++;
        if (observe(s) !== model(0, 1, 1, 1, 1'b0, 8'h00, 8'h00) || rdata_of(s) !== 8'h00) begin
          errors++;
          $display("FAIL reset_hold dut%0d c=%0d got=%h rdata=%h", s, c, observe(s), rdata_of(s));
        end
      end
    end
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    idle_cycles("reset_release0", 0, 2);
    idle_cycles("reset_release1", 1, 1);
  endtask

  task automatic test_reset_abort();
    obs_t e;
    rw = 1'b1; addr = 8'($urandom); req0 = 1'b1;
    for (int j = 1; j <= TP + TH + 2; j++) begin
      @(negedge CLK);
      req0 = 1'b0;
      ADin = 8'hFF;
      e = model(j, TP, TH, TG, 1'b1, addr, 8'h00);
      checks++;
      if (busy0 !== e.busy || rd0 !== e.rd || oe0 !== e.oe) begin
        errors++;
        $display("FAIL abort_pre j=%0d busy=%b rd=%b oe=%b exp=%b%b%b", j, busy0, rd0, oe0, e.busy, e.rd, e.oe);
      end
    end
    reset = 1'b0;
    exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
    @(negedge CLK);
    reset = 1'b1;
    ADin = 8'h37;
    checks++;
    if (observe(0) !== model(0, 1, 1, 1, 1'b0, 8'h00, 8'h00) || rdata0 !== exp_rdata[0]) begin
      errors++;
      $display("FAIL abort_idle got=%h rdata=%h exp_rdata=%h", observe(0), rdata0, exp_rdata[0]);
    end
    idle_cycles("abort_no_done", 0, 16);
  endtask

  task automatic test_write();
    do_transfer("write_default", 0, 1'b0, 8'h21, 8'h59, 8'h00, 1'b0);
    idle_cycles("write_after", 0, 2);
  endtask

  task automatic test_read();
    do_transfer("read_default", 0, 1'b1, 8'h22, 8'h00, 8'h37, 1'b0);
    idle_cycles("read_after", 0, 2);
  endtask

  task automatic test_ignored_req();
    do_transfer("ignored_req", 0, 1'b0, 8'($urandom), 8'($urandom), 8'h00, 1'b1);
    idle_cycles("ignored_one_done", 0, 18);
  endtask

  task automatic test_back_to_back();
    do_transfer("b2b_first", 0, 1'b1, 8'h40, 8'h00, 8'($urandom), 1'b0);
    do_transfer("b2b_second", 0, 1'b0, 8'h41, 8'($urandom), 8'h00, 1'b0);
    do_transfer("b2b_third", 0, 1'b1, 8'h42, 8'h00, 8'($urandom), 1'b0);
    idle_cycles("b2b_after", 0, 2);
  endtask

  task automatic test_param_sweep();
    do_transfer("sweep_read", 1, 1'b1, 8'h10, 8'h00, 8'hC3, 1'b0);
    idle_cycles("sweep_after", 1, 2);
    do_transfer("sweep_write", 1, 1'b0, 8'($urandom), 8'($urandom), 8'h00, 1'b0);
    do_transfer("sweep_b2b", 1, 1'b1, 8'($urandom), 8'h00, 8'($urandom), 1'b0);
    idle_cycles("sweep_after2", 1, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int sel;
      sel = int'($urandom_range(1, 0));
      do_transfer("random", sel, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  (sel == 0) ? 1'($urandom) : 1'b0);
      if ($urandom_range(1, 0) == 0) idle_cycles("random_gap", sel, 1 + int'($urandom_range(2, 0)));
      else idle_cycles("random_gap", sel, 0);
      idle_cycles("random_settle", sel, (sel == 0) ? 17 : 1);
    end
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; rw = 1'b0;
    addr = 8'h00; wdata = 8'h00; ADin = 8'hFF;
    exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
    test_reset();
    test_reset_abort();
    test_write();
    test_read();
    test_ignored_req();
    test_back_to_back();
    test_param_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
